// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file transfer controller:
// command op encodings, controller state encoding and default widths.
package regfile_pkg;

  localparam int RF_DATA_W = 16;
  localparam int RF_ADDR_W = 3;

  typedef enum logic [1:0] {
    OP_LDI  = 2'b00,
    OP_COPY = 2'b01,
    OP_SWAP = 2'b10,
    OP_READ = 2'b11
  } op_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD_A = 3'd1,
    RD_B = 3'd2,
    WR_A = 3'd3,
    WR_B = 3'd4,
    DONE = 3'd5
  } state_t;

endpackage

// File: rtl/regfile_xfer_ctrl_if.sv
// Command handshake plus register-file bus seen by the transfer controller.
//
// Handshake: a command transfers on a rising clk edge where cmd_valid and
// cmd_ready are both 1. cmd_ready depends only on controller state and reset,
// never on cmd_valid. cmd_* fields are only looked at on that edge. done is a
// single-cycle pulse; resp_data is meaningful only while done=1 and 0 otherwise.
//
// master: the controller (drives rf_*, cmd_ready, done, resp_data).
// slave : front end + regfile (drive cmd_*, rf_data_out).
interface regfile_xfer_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_rd;
  logic [ADDR_W-1:0] cmd_rs;
  logic [DATA_W-1:0] cmd_imm;
  logic              done;
  logic [DATA_W-1:0] resp_data;
  logic              rf_write;
  logic [ADDR_W-1:0] rf_writenum;
  logic [ADDR_W-1:0] rf_readnum;
  logic [DATA_W-1:0] rf_data_in;
  logic [DATA_W-1:0] rf_data_out;

  modport master (
    input  cmd_valid, cmd_op, cmd_rd, cmd_rs, cmd_imm, rf_data_out,
    output cmd_ready, done, resp_data, rf_write, rf_writenum, rf_readnum, rf_data_in
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_rd, cmd_rs, cmd_imm, rf_data_out,
    input  cmd_ready, done, resp_data, rf_write, rf_writenum, rf_readnum, rf_data_in
  );
endinterface

// File: rtl/load_enable.sv
// Register with synchronous clear and load enable; holds otherwise.
module load_enable #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);
  // Clear on reset, capture d when load is high.
  always_ff @(posedge clk) begin
    if (reset)     q <= '0;
    else if (load) q <= d;
  end
endmodule

// File: rtl/regfile.sv
// 2**ADDR_W x DATA_W register file: one synchronous write port and one
// combinational read port. Contents are not cleared by any reset.
module regfile #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              write,
  input  logic [ADDR_W-1:0] writenum,
  input  logic [ADDR_W-1:0] readnum,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out
);
  logic [DATA_W-1:0] regs [2**ADDR_W];

  // Write port commits on the rising edge.
  always_ff @(posedge clk) begin
    if (write) regs[writenum] <= data_in;
  end

  assign data_out = regs[readnum];
endmodule

// File: rtl/regfile_xfer_ctrl_xfer_fsm.sv
// Sequencing FSM: walks RD_A/RD_B/WR_A/WR_B/DONE for the latched op and
// decodes the register-file controls, done pulse and response from state.
module xfer_fsm
  import regfile_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  input  op_t               cmd_op,
  input  op_t               op_q,
  input  logic [ADDR_W-1:0] rd_q,
  input  logic [ADDR_W-1:0] rs_q,
  input  logic [DATA_W-1:0] a_q,
  input  logic [DATA_W-1:0] b_q,
  output state_t            state,
  output logic              accept,
  output logic              cmd_ready,
  output logic              done,
  output logic [DATA_W-1:0] resp_data,
  output logic              rf_write,
  output logic [ADDR_W-1:0] rf_writenum,
  output logic [ADDR_W-1:0] rf_readnum,
  output logic [DATA_W-1:0] rf_data_in
);
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] readnum_q, writenum_q;
  logic [DATA_W-1:0] data_in_q;

  assign state  = state_q;
  assign accept = cmd_valid & cmd_ready;

  // State register plus hold copies so rf addresses/data keep their last value.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      readnum_q  <= '0;
      writenum_q <= '0;
      data_in_q  <= '0;
    end else begin
      state_q    <= state_d;
      readnum_q  <= rf_readnum;
      writenum_q <= rf_writenum;
      data_in_q  <= rf_data_in;
    end
  end

  // Next state and output decode; writes are suppressed on a reset cycle.
  always_comb begin
    state_d     = state_q;
    cmd_ready   = 1'b0;
    done        = 1'b0;
    resp_data   = '0;
    rf_write    = 1'b0;
    rf_writenum = writenum_q;
    rf_readnum  = readnum_q;
    rf_data_in  = data_in_q;
    case (state_q)
      IDLE: begin
        cmd_ready = ~reset;
        if (accept) state_d = (cmd_op == OP_LDI) ? WR_A : RD_A;
      end
      RD_A: begin
        rf_readnum = rs_q;
        if (op_q == OP_READ)      state_d = DONE;
        else if (op_q == OP_SWAP) state_d = RD_B;
        else                      state_d = WR_A;
      end
      RD_B: begin
        rf_readnum = rd_q;
        state_d    = WR_A;
      end
      WR_A: begin
        rf_write    = ~reset;
        rf_writenum = rd_q;
        rf_data_in  = a_q;
        state_d     = (op_q == OP_SWAP) ? WR_B : DONE;
      end
      WR_B: begin
        rf_write    = ~reset;
        rf_writenum = rs_q;
        rf_data_in  = b_q;
        state_d     = DONE;
      end
      DONE: begin
        done      = 1'b1;
        resp_data = (op_q == OP_READ) ? a_q : '0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: rtl/regfile_xfer_ctrl.sv
// Register-transfer command initiator for the regfile: latches the command
// and the A/B operand registers, and lets xfer_fsm sequence the regfile.
module regfile_xfer_ctrl
  import regfile_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic                  clk,
  input  logic                  reset,
  regfile_xfer_ctrl_if.master   bus,
  output state_t                dbg_state
);
  state_t            state;
  logic              accept;
  op_t               op_q;
  logic [ADDR_W-1:0] rd_q, rs_q;
  logic              a_load, b_load;
  logic [DATA_W-1:0] a_d, a_q, b_q;

  // Command latch, captured only on the accepting edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q <= OP_LDI;
      rd_q <= '0;
      rs_q <= '0;
    end else if (accept) begin
      op_q <= op_t'(bus.cmd_op);
      rd_q <= bus.cmd_rd;
      rs_q <= bus.cmd_rs;
    end
  end

  // A takes the immediate on an LDI acceptance or the read data in RD_A.
  assign a_load = (state == RD_A) | (accept & (op_t'(bus.cmd_op) == OP_LDI));
  assign a_d    = (state == RD_A) ? bus.rf_data_out : bus.cmd_imm;
  assign b_load = (state == RD_B);

  load_enable #(.N(DATA_W)) u_a (
    .clk(clk), .reset(reset), .load(a_load), .d(a_d), .q(a_q)
  );

  load_enable #(.N(DATA_W)) u_b (
    .clk(clk), .reset(reset), .load(b_load), .d(bus.rf_data_out), .q(b_q)
  );

  xfer_fsm #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fsm (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (bus.cmd_valid),
    .cmd_op     (op_t'(bus.cmd_op)),
    .op_q       (op_q),
    .rd_q       (rd_q),
    .rs_q       (rs_q),
    .a_q        (a_q),
    .b_q        (b_q),
    .state      (state),
    .accept     (accept),
    .cmd_ready  (bus.cmd_ready),
    .done       (bus.done),
    .resp_data  (bus.resp_data),
    .rf_write   (bus.rf_write),
    .rf_writenum(bus.rf_writenum),
    .rf_readnum (bus.rf_readnum),
    .rf_data_in (bus.rf_data_in)
  );

  assign dbg_state = state;
endmodule

// File: tb/tb_regfile_xfer_ctrl.sv
// Bench for regfile_xfer_ctrl driving a real regfile: directed vector table,
// hand-written reset/back-pressure sequences and random commands checked
// against an array model of the register contents.
module tb_regfile_xfer_ctrl;
  import regfile_pkg::*;

  logic   clk;
  logic   reset;
  state_t dbg_state;

  regfile_xfer_ctrl_if #(.DATA_W(16), .ADDR_W(3)) bus ();

  regfile_xfer_ctrl #(.DATA_W(16), .ADDR_W(3)) dut (
    .clk(clk), .reset(reset), .bus(bus), .dbg_state(dbg_state)
  );

  regfile #(.DATA_W(16), .ADDR_W(3)) u_rf (
    .clk     (clk),
    .write   (bus.rf_write),
    .writenum(bus.rf_writenum),
    .readnum (bus.rf_readnum),
    .data_in (bus.rf_data_in),
    .data_out(bus.rf_data_out)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [15:0] model [8];

  typedef struct {
    logic [1:0]  op;
    logic [2:0]  rd;
    logic [2:0]  rs;
    logic [15:0] imm;
    logic [15:0] exp_resp;
    int          exp_cycles;
    int          exp_writes;
  } vec_t;

  vec_t tbl [16];

  function automatic vec_t mk(input logic [1:0] op, input logic [2:0] rd, input logic [2:0] rs,
                              input logic [15:0] imm, input logic [15:0] er, input int ec, input int ew);
    vec_t v;
    v.op = op; v.rd = rd; v.rs = rs; v.imm = imm;
    v.exp_resp = er; v.exp_cycles = ec; v.exp_writes = ew;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: what each command does to the register contents.
  task automatic model_apply(input logic [1:0] op, input logic [2:0] rd, input logic [2:0] rs,
                             input logic [15:0] imm, output logic [15:0] resp);
    logic [15:0] t;
    resp = 16'h0;
    case (op)
      OP_LDI:  model[rd] = imm;
      OP_COPY: model[rd] = model[rs];
      OP_SWAP: begin t = model[rd]; model[rd] = model[rs]; model[rs] = t; end
      default: resp = model[rs];
    endcase
  endtask

  function automatic int exp_latency(input logic [1:0] op);
    case (op)
      OP_LDI:  return 2;
      OP_COPY: return 3;
      OP_SWAP: return 5;
      default: return 2;
    endcase
  endfunction

  function automatic int exp_nwrites(input logic [1:0] op);
    case (op)
      OP_LDI, OP_COPY: return 1;
      OP_SWAP:         return 2;
      default:         return 0;
    endcase
  endfunction

  // Driver: issue one command from IDLE and observe it until done (bounded).
  task automatic do_cmd(input logic [1:0] op, input logic [2:0] rd, input logic [2:0] rs,
                        input logic [15:0] imm, output logic [15:0] resp, output int cycles,
                        output int writes, output int rdy_low);
    bit got;
    int stray;
    got = 0; stray = 0; writes = 0; rdy_low = 0; cycles = 0; resp = 16'h0;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op = op; bus.cmd_rd = rd; bus.cmd_rs = rs; bus.cmd_imm = imm;
    check("ready_before_cmd", 32'(bus.cmd_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op  = 2'($urandom_range(0, 3));
    bus.cmd_rd  = 3'($urandom_range(0, 7));
    bus.cmd_rs  = 3'($urandom_range(0, 7));
    bus.cmd_imm = 16'($urandom);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      cycles++;
      if (bus.rf_write) writes++;
      if (!bus.cmd_ready) rdy_low++;
      if (bus.done) begin
        resp = bus.resp_data;
        got = 1;
        break;
      end else if (bus.resp_data !== 16'h0) begin
        stray++;
      end
    end
    if (!got) cycles = -1;
    check("resp_zero_when_not_done", 32'(stray), 32'd0);
  endtask

  task automatic run_cmd(input string tag, input logic [1:0] op, input logic [2:0] rd,
                         input logic [2:0] rs, input logic [15:0] imm);
    logic [15:0] er, resp;
    int cyc, wr, rl;
    model_apply(op, rd, rs, imm, er);
    do_cmd(op, rd, rs, imm, resp, cyc, wr, rl);
    check({tag, "_resp"},    32'(resp), 32'(er));
    check({tag, "_cycles"},  32'(cyc),  32'(exp_latency(op)));
    check({tag, "_writes"},  32'(wr),   32'(exp_nwrites(op)));
  endtask

  initial begin
    logic [15:0] er, resp;
    int cyc, wr, rl, cnt;
    int acc, dn, wq, overlap, bad_acc, bad_gap, cycn, last_acc;
    logic [15:0] qimm [4];
    logic [2:0]  qrd  [4];
    bit take;

    bus.cmd_valid = 1'b1;
    bus.cmd_op = OP_LDI; bus.cmd_rd = 3'd5; bus.cmd_rs = 3'd0; bus.cmd_imm = 16'hDEAD;
    reset = 1'b1;

    // Reset with cmd_valid held high: never ready, nothing accepted.
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.cmd_ready !== 1'b0) cnt++;
    end
    check("ready_low_in_reset", 32'(cnt), 32'd0);
    check("rf_write_in_reset",  32'(bus.rf_write), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    check("rst_state",     32'(dbg_state),       32'(IDLE));
    check("rst_ready",     32'(bus.cmd_ready),   32'd1);
    check("rst_done",      32'(bus.done),        32'd0);
    check("rst_resp",      32'(bus.resp_data),   32'd0);
    check("rst_write",     32'(bus.rf_write),    32'd0);
    check("rst_writenum",  32'(bus.rf_writenum), 32'd0);
    check("rst_readnum",   32'(bus.rf_readnum),  32'd0);
    check("rst_data_in",   32'(bus.rf_data_in),  32'd0);

    // Directed vector table.
    tbl[0]  = mk(OP_LDI,  3'd3, 3'd0, 16'h00A5, 16'h0000, 2, 1);
    tbl[1]  = mk(OP_READ, 3'd0, 3'd3, 16'h0000, 16'h00A5, 2, 0);
    tbl[2]  = mk(OP_LDI,  3'd1, 3'd0, 16'h1234, 16'h0000, 2, 1);
    tbl[3]  = mk(OP_LDI,  3'd6, 3'd0, 16'hBEEF, 16'h0000, 2, 1);
    tbl[4]  = mk(OP_SWAP, 3'd1, 3'd6, 16'h0000, 16'h0000, 5, 2);
    tbl[5]  = mk(OP_READ, 3'd0, 3'd1, 16'h0000, 16'hBEEF, 2, 0);
    tbl[6]  = mk(OP_READ, 3'd0, 3'd6, 16'h0000, 16'h1234, 2, 0);
    tbl[7]  = mk(OP_LDI,  3'd0, 3'd0, 16'hFFFF, 16'h0000, 2, 1);
    tbl[8]  = mk(OP_COPY, 3'd7, 3'd0, 16'h0000, 16'h0000, 3, 1);
    tbl[9]  = mk(OP_READ, 3'd0, 3'd7, 16'h0000, 16'hFFFF, 2, 0);
    tbl[10] = mk(OP_READ, 3'd0, 3'd0, 16'h0000, 16'hFFFF, 2, 0);
    tbl[11] = mk(OP_LDI,  3'd2, 3'd0, 16'h0F0F, 16'h0000, 2, 1);
    tbl[12] = mk(OP_SWAP, 3'd2, 3'd2, 16'h0000, 16'h0000, 5, 2);
    tbl[13] = mk(OP_READ, 3'd0, 3'd2, 16'h0000, 16'h0F0F, 2, 0);
    tbl[14] = mk(OP_LDI,  3'd1, 3'd0, 16'h1111, 16'h0000, 2, 1);
    tbl[15] = mk(OP_LDI,  3'd6, 3'd0, 16'h6666, 16'h0000, 2, 1);

    for (int i = 0; i < 16; i++) begin
      model_apply(tbl[i].op, tbl[i].rd, tbl[i].rs, tbl[i].imm, er);
      do_cmd(tbl[i].op, tbl[i].rd, tbl[i].rs, tbl[i].imm, resp, cyc, wr, rl);
      check($sformatf("tbl%0d_resp", i),    32'(resp), 32'(tbl[i].exp_resp));
      check($sformatf("tbl%0d_cycles", i),  32'(cyc),  32'(tbl[i].exp_cycles));
      check($sformatf("tbl%0d_writes", i),  32'(wr),   32'(tbl[i].exp_writes));
      check($sformatf("tbl%0d_rdy_low", i), 32'(rl),   32'(tbl[i].exp_cycles));
    end

    // Reset during RD_B of a SWAP R1<->R6: aborted, nothing written.
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op = OP_SWAP; bus.cmd_rd = 3'd1; bus.cmd_rs = 3'd6; bus.cmd_imm = 16'h0;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check("abort_in_rd_b",    32'(dbg_state),     32'(RD_B));
    check("abort_write",      32'(bus.rf_write),  32'd0);
    check("abort_ready_rst",  32'(bus.cmd_ready), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("abort_idle",       32'(dbg_state),      32'(IDLE));
    check("abort_ready_after",32'(bus.cmd_ready),  32'd1);
    check("abort_readnum",    32'(bus.rf_readnum), 32'd0);
    check("abort_done",       32'(bus.done),       32'd0);
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.rf_write) cnt++;
    end
    check("abort_no_writes", 32'(cnt), 32'd0);
    run_cmd("abort_r1", OP_READ, 3'd0, 3'd1, 16'h0);
    run_cmd("abort_r6", OP_READ, 3'd0, 3'd6, 16'h0);

    // Four LDIs queued with cmd_valid held high.
    qrd[0] = 3'd4; qrd[1] = 3'd5; qrd[2] = 3'd4; qrd[3] = 3'd7;
    for (int i = 0; i < 4; i++) qimm[i] = 16'($urandom);
    acc = 0; dn = 0; wq = 0; overlap = 0; bad_acc = 0; bad_gap = 0; last_acc = -1;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op = OP_LDI; bus.cmd_rd = qrd[0]; bus.cmd_rs = 3'd0; bus.cmd_imm = qimm[0];
    for (cycn = 0; cycn < 40 && dn < 4; cycn++) begin
      if (bus.done) dn++;
      if (bus.rf_write) wq++;
      if (bus.rf_write && bus.cmd_ready) overlap++;
      take = bus.cmd_valid && bus.cmd_ready;
      if (take && dbg_state != IDLE) bad_acc++;
      if (take && last_acc >= 0 && (cycn - last_acc) != 3) bad_gap++;
      @(posedge clk);
      #1;
      if (take) begin
        model_apply(OP_LDI, qrd[acc], 3'd0, qimm[acc], er);
        last_acc = cycn;
        acc++;
        if (acc < 4) begin
          bus.cmd_rd = qrd[acc]; bus.cmd_imm = qimm[acc];
        end else begin
          bus.cmd_valid = 1'b0;
        end
      end
      @(negedge clk);
    end
    bus.cmd_valid = 1'b0;
    check("queue_accepts",   32'(acc),     32'd4);
    check("queue_dones",     32'(dn),      32'd4);
    check("queue_writes",    32'(wq),      32'd4);
    check("queue_overlap",   32'(overlap), 32'd0);
    check("queue_bad_accept",32'(bad_acc), 32'd0);
    check("queue_gap",       32'(bad_gap), 32'd0);
    run_cmd("queue_r4", OP_READ, 3'd0, 3'd4, 16'h0);
    run_cmd("queue_r5", OP_READ, 3'd0, 3'd5, 16'h0);
    run_cmd("queue_r7", OP_READ, 3'd0, 3'd7, 16'h0);

    // Random commands against the model, starting from fully written registers.
    for (int r = 0; r < 8; r++) run_cmd("init", OP_LDI, 3'(r), 3'd0, 16'($urandom));
    for (int i = 0; i < 150; i++) begin
      run_cmd("rand", 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
              3'($urandom_range(0, 7)), 16'($urandom));
    end
    for (int r = 0; r < 8; r++) run_cmd("final", OP_READ, 3'd0, 3'(r), 16'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
